// File: rtl/tengphy_pcs_pkg.sv
// Shared constants and types for the 10GBASE-R PCS transmit path
// (XGMII characters, 7-bit control codes, 64b/66b block types and sync headers).
package tengphy_pcs_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;
    localparam logic [7:0] XGMII_ERR   = 8'hFE;

    localparam logic [6:0] IDLE_C = 7'h00;
    localparam logic [6:0] ERR_C  = 7'h1E;

    localparam logic [7:0] BT_IDLE = 8'h1E;
    localparam logic [7:0] BT_S0   = 8'h78;
    localparam logic [7:0] BT_S4   = 8'h33;
    localparam logic [7:0] BT_OS   = 8'h4B;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [2:0] {
        TX_INIT = 3'd0,
        TX_C    = 3'd1,
        TX_D    = 3'd2,
        TX_T    = 3'd3,
        TX_E    = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        CLS_C = 3'd0,
        CLS_S = 3'd1,
        CLS_D = 3'd2,
        CLS_T = 3'd3,
        CLS_E = 3'd4
    } blk_class_e;

    // Block type of a terminate block whose /T/ sits in lane n
    function automatic logic [7:0] term_type(input logic [2:0] n);
        logic [7:0] t;
        case (n)
            3'd0:    t = 8'h87;
            3'd1:    t = 8'h99;
            3'd2:    t = 8'hAA;
            3'd3:    t = 8'hB4;
            3'd4:    t = 8'hCC;
            3'd5:    t = 8'hD2;
            3'd6:    t = 8'hE1;
            3'd7:    t = 8'hFF;
            default: t = 8'h87;
        endcase
        return t;
    endfunction

    // Control block carrying /E/ in all eight lanes
    function automatic logic [63:0] error_block();
        return {{8{ERR_C}}, BT_IDLE};
    endfunction

endpackage

// File: rtl/pcs_block_classify.sv
// Combinational 64b/66b block encoder: maps one 8-lane XGMII block to a payload,
// sync header and block class for the TX state machine.
module pcs_block_classify
    import tengphy_pcs_pkg::*;
(
    input  logic [63:0] blk_data,
    input  logic [7:0]  blk_ctrl,
    output logic [63:0] blk_payload,
    output logic [1:0]  blk_head,
    output blk_class_e  blk_class
);

    logic [7:0]  lane_ic_s;
    logic [55:0] ctrl_codes_s;
    logic [7:0]  term_match_s;
    logic [2:0]  term_n_s;
    logic [5:0]  term_csh_s;
    logic [55:0] term_dmask_s;
    logic [55:0] term_cmask_s;

    // Per-lane idle/error detection and the 7-bit code each lane would carry
    always_comb begin
        lane_ic_s    = 8'h00;
        ctrl_codes_s = 56'h0;
        for (int k = 0; k < 8; k++) begin
            lane_ic_s[k] = blk_ctrl[k] & ((blk_data[8*k +: 8] == XGMII_IDLE) |
                                          (blk_data[8*k +: 8] == XGMII_ERR));
            ctrl_codes_s[7*k +: 7] = (blk_data[8*k +: 8] == XGMII_IDLE) ? IDLE_C : ERR_C;
        end
    end

    // Terminate search; the required ctrl pattern allows at most one match
    always_comb begin
        term_match_s = 8'h00;
        term_n_s     = 3'd0;
        for (int n = 0; n < 8; n++) begin
            term_match_s[n] = (blk_ctrl == (8'hFF << n)) &&
                              (blk_data[8*n +: 8] == XGMII_TERM) &&
                              ((lane_ic_s | ~(8'hFE << n)) == 8'hFF);
            term_n_s = term_n_s | (term_match_s[n] ? 3'(n) : 3'd0);
        end
        // data bytes fill from bit 8 upward, codes C(n+1)..C7 keep their slots below bit 63
        term_csh_s   = 6'd7 * ({3'b000, term_n_s} + 6'd1);
        term_dmask_s = (56'h1 << {term_n_s, 3'b000}) - 56'h1;
        term_cmask_s = ~((56'h1 << term_csh_s) - 56'h1);
    end

    // Block class, header and payload selection
    always_comb begin
        blk_payload = 64'h0;
        blk_head    = SH_CTRL;
        blk_class   = CLS_E;
        if (blk_ctrl == 8'h00) begin
            blk_payload = blk_data;
            blk_head    = SH_DATA;
            blk_class   = CLS_D;
        end else if (lane_ic_s == 8'hFF) begin
            blk_payload = {ctrl_codes_s, BT_IDLE};
            blk_class   = CLS_C;
        end else if ((blk_ctrl == 8'h01) && (blk_data[7:0] == XGMII_START)) begin
            blk_payload = {blk_data[63:8], BT_S0};
            blk_class   = CLS_S;
        end else if ((blk_ctrl == 8'h1F) && (lane_ic_s[3:0] == 4'hF) &&
                     (blk_data[39:32] == XGMII_START)) begin
            blk_payload = {blk_data[63:40], 4'h0, ctrl_codes_s[27:0], BT_S4};
            blk_class   = CLS_S;
        end else if ((blk_ctrl == 8'hF1) && (blk_data[7:0] == XGMII_SEQ) &&
                     (lane_ic_s[7:4] == 4'hF)) begin
            blk_payload = {ctrl_codes_s[55:28], 4'h0, blk_data[31:8], BT_OS};
            blk_class   = CLS_C;
        end else if (term_match_s != 8'h00) begin
            blk_payload = {(blk_data[55:0] & term_dmask_s) | (ctrl_codes_s & term_cmask_s),
                           term_type(term_n_s)};
            blk_class   = CLS_T;
        end else begin
            blk_payload = 64'h0;
            blk_head    = SH_CTRL;
            blk_class   = CLS_E;
        end
    end

endmodule

// File: rtl/xgmii_64b66b_encode.sv
// 10GBASE-R transmit encoder: pairs 32-bit XGMII beats into 8-lane blocks, runs the
// TX state machine and registers one 66-bit block per completed pair.
module xgmii_64b66b_encode
    import tengphy_pcs_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [31:0]          xgmii_txd_i,
    input  logic [3:0]           xgmii_txc_i,
    input  logic                 xgmii_txd_vld_i,
    output logic [63:0]          encode_data_o,
    output logic [1:0]           encode_head_o,
    output logic                 encode_data_vld_o,
    output logic                 encode_error_o,
    output logic [ERR_CNT_W-1:0] encode_err_cnt_o
);

    logic                 phase_r;
    logic [31:0]          half_data_r;
    logic [3:0]           half_ctrl_r;
    tx_state_e            state_r;
    tx_state_e            state_next_s;
    logic                 blk_done_s;
    logic [63:0]          cls_payload_s;
    logic [1:0]           cls_head_s;
    blk_class_e           cls_class_s;
    logic [63:0]          blk_data_s;
    logic [1:0]           blk_head_s;
    logic                 blk_error_s;
    logic [63:0]          data_r;
    logic [1:0]           head_r;
    logic                 vld_r;
    logic                 error_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    assign blk_done_s = xgmii_txd_vld_i & phase_r;

    pcs_block_classify u_classify (
        .blk_data    ({xgmii_txd_i, half_data_r}),
        .blk_ctrl    ({xgmii_txc_i, half_ctrl_r}),
        .blk_payload (cls_payload_s),
        .blk_head    (cls_head_s),
        .blk_class   (cls_class_s)
    );

    // Beat pairing: phase advances only on valid beats; phase-0 beat is held as lanes 0-3
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_r     <= 1'b0;
            half_data_r <= 32'h0;
            half_ctrl_r <= 4'h0;
        end else if (xgmii_txd_vld_i) begin
            phase_r <= ~phase_r;
            if (!phase_r) begin
                half_data_r <= xgmii_txd_i;
                half_ctrl_r <= xgmii_txc_i;
            end
        end
    end

    // TX state register, advanced once per assembled block
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= TX_INIT;
        end else if (blk_done_s) begin
            state_r <= state_next_s;
        end
    end

    // Next state and block selection; every block that lands in TX_E is replaced
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            TX_INIT, TX_C, TX_T: begin
                case (cls_class_s)
                    CLS_C:   state_next_s = TX_C;
                    CLS_S:   state_next_s = TX_D;
                    default: state_next_s = TX_E;
                endcase
            end
            TX_D: begin
                case (cls_class_s)
                    CLS_D:   state_next_s = TX_D;
                    CLS_T:   state_next_s = TX_T;
                    default: state_next_s = TX_E;
                endcase
            end
            TX_E: begin
                case (cls_class_s)
                    CLS_D:   state_next_s = TX_D;
                    CLS_C:   state_next_s = TX_C;
                    CLS_T:   state_next_s = TX_T;
                    default: state_next_s = TX_E;
                endcase
            end
            default: state_next_s = TX_INIT;
        endcase

        if (state_next_s == TX_E) begin
            blk_data_s  = error_block();
            blk_head_s  = SH_CTRL;
            blk_error_s = 1'b1;
        end else begin
            blk_data_s  = cls_payload_s;
            blk_head_s  = cls_head_s;
            blk_error_s = 1'b0;
        end
    end

    // Output registers and saturating error counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_r    <= 64'h0;
            head_r    <= 2'b00;
            vld_r     <= 1'b0;
            error_r   <= 1'b0;
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else begin
            vld_r   <= blk_done_s;
            error_r <= blk_done_s & blk_error_s;
            if (blk_done_s) begin
                data_r <= blk_data_s;
                head_r <= blk_head_s;
            end
            if (blk_done_s && blk_error_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign encode_data_o     = data_r;
    assign encode_head_o     = head_r;
    assign encode_data_vld_o = vld_r;
    assign encode_error_o    = error_r;
    assign encode_err_cnt_o  = err_cnt_r;

endmodule

// File: doc/xgmii_64b66b_encode.md
Name: xgmii_64b66b_encode

Overview:
- Transmit-side 64b/66b encoder for the 10G PHY, per IEEE 802.3 Clause 49.
- Accepts 32-bit XGMII TX beats from the MAC at 312.5 MHz (156.25×2). Pairs two beats into one 8-lane block, classifies it, and emits a 64-bit block plus a 2-bit sync header towards the scrambler/gearbox feeding the GTX.
- Runs the Clause 49 TX state machine, so illegal sequences are replaced by error blocks.
- Output is unscrambled; scrambling is a separate block.

Parameters:
ERR_CNT_W, 16, width of the saturating encode-error counter

Ports:
clk_i  input  1  clock, 156.25×2 MHz
rst_n_i  input  1  asynchronous active-low reset
xgmii_txd_i  input  32  TX data, lane k in bits [8k+7:8k]
xgmii_txc_i  input  4  TX control flag per lane; 1 = control character
xgmii_txd_vld_i  input  1  beat valid
encode_data_o  output  64  block payload; bits [7:0] = first byte (block type or D0)
encode_head_o  output  2  sync header: 2'b01 = data block, 2'b10 = control block
encode_data_vld_o  output  1  block valid, one-cycle pulse
encode_error_o  output  1  pulse with a block that was substituted by an error block
encode_err_cnt_o  output  ERR_CNT_W  saturating count of error blocks

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low, rst_n_i.
- Reset values: all outputs 0; half-phase = 0; state = TX_INIT.
- Beat pairing:
  - The half-phase bit toggles only on valid beats, so gaps in xgmii_txd_vld_i hold the phase.
  - Phase 0 beat → lanes 0-3, stored in a register.
  - Phase 1 beat → lanes 4-7; the block is assembled from the stored half plus the current beat.
- Latency: encode_data_vld_o pulses exactly 1 cycle after the phase-1 beat. Peak output rate is one block per 2 cycles.
- Character map:
  - 0x07 → 7-bit 0x00; 0xFE → 0x1E.
  - Any other control character outside S/T/O positions → block class E.
- Block types (header 10):
  - 0x1E: all 8 lanes idle/error. C0..C7 at [14:8],[21:15],…,[63:57].
  - 0x78: lane0 = 0xFB, lanes 1-7 data. D1..D7 at [63:8].
  - 0x33: lanes 0-3 idle/error, lane4 = 0xFB, lanes 5-7 data. C0..C3 at [35:8], [39:36]=0, D5..D7 at [63:40].
  - 0x4B: lane0 = 0x9C, lanes 1-3 data, lanes 4-7 idle. D1..D3 at [31:8], O0=[35:32]=0, C4..C7 at [63:36].
  - Terminate Tn, n = 0..7, types 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF:
    - lanes 0..n-1 data, lane n = 0xFD, lanes n+1..7 idle/error;
    - D0..Dn-1 from [15:8] upward;
    - C(n+1)..C7 packed 7 bits each ending at bit 63;
    - gap bits = 0.
- Data block: all txc = 0 → header 01, payload = raw lanes.
- Classes:
  - C: 0x1E or 0x4B.
  - S: 0x78 or 0x33.
  - D: data block.
  - T: terminate block.
  - E: anything else, including a mixed txc pattern not listed above.
- TX state machine, evaluated per assembled block:
  - TX_INIT and TX_C: C→TX_C; S→TX_D; else →TX_E.
  - TX_D: D→TX_D; T→TX_T; else →TX_E.
  - TX_T: same transitions as TX_C.
  - TX_E: D→TX_D; C→TX_C; T→TX_T; else stay TX_E.
- Output on entry:
  - Entering TX_E → emit error block: header 10, [7:0]=0x1E, all eight 7-bit fields = 0x1E; encode_error_o = 1.
  - Any other transition → emit the encoded block.
- Error counter: increments on each error block and saturates at all-ones; it does not wrap.
- Reset mid-block: the stored half is discarded; phase returns to 0.

Decomposition:
- Package tengphy_pcs_pkg holds:
  - XGMII characters: IDLE 0x07, START 0xFB, TERM 0xFD, SEQ 0x9C, ERR 0xFE;
  - 7-bit codes: IDLE_C 0x00, ERR_C 0x1E;
  - block-type constants;
  - sync header constants SH_DATA 2'b01, SH_CTRL 2'b10;
  - TX state enum.
- One sub-module: pcs_block_classify, purely combinational. Maps 64b data + 8b ctrl → 64b payload, header, and class. The top module owns pairing, the FSM and output registers.

Test Plan:
- Reset, then 4 beats of txd=0x07070707, txc=0xF → two blocks: header 10, data 0x000000000000001E; vld 1 cycle after each 2nd beat; error=0.
- Idle, then start beat txd=0x555555FB txc=0x1, then txd=0xD5555555 txc=0x0 → header 10, data 0xD555555555555578.
- In TX_D, beats 0x04030201 / 0x08070605 with txc=0 → header 01, data 0x0807060504030201.
- In TX_D, beats 0xFD332211 txc=0x8, then 0x07070707 txc=0xF → T3: header 10, data 0x00000000332211B4; next idle block accepted as TX_C.
- Data block while in TX_C, or start while in TX_D → error block with [7:0]=0x1E and all 7-bit fields 0x1E; encode_error_o pulses; err_cnt goes 0→1; a later valid start returns to normal.
- Valid gaps of 3 cycles between halves → pairing and phase preserved. Assert rst_n_i after one half → outputs 0, next beat treated as phase 0; counter preset near max → saturates.
